// File: rtl/irq_controller_multi.sv
// Multi-line interrupt controller.
// Requests are masked per line and arbitrated by fixed priority, with line 0 highest.
// Each line is either rising-edge or level sensitive.
// Exception and interrupt service state is tracked, including an exception
// raised while an interrupt handler is running.
module irq_controller_multi #(
  parameter int unsigned        IRQ_NUM    = 16,
  parameter logic [IRQ_NUM-1:0] EDGE_MASK  = '0,
  parameter logic [31:0]        CAUSE_BASE = 32'h1000_0010,
  localparam int unsigned       ID_W       = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               exception_i,
  input  logic               mret_i,
  input  logic               mie_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [IRQ_NUM-1:0] irq_mask_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic               irq_ret_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_IRQ        = 2'd1,
    ST_EXC        = 2'd2,
    ST_EXC_IN_IRQ = 2'd3
  } state_e;

  state_e             state_q;
  logic [IRQ_NUM-1:0] req_q;
  logic [IRQ_NUM-1:0] pend_q;
  logic [IRQ_NUM-1:0] pend_d;
  logic [ID_W-1:0]    id_q;

  logic [IRQ_NUM-1:0] edge_rise;
  logic [IRQ_NUM-1:0] pend;
  logic [IRQ_NUM-1:0] cand;
  logic [ID_W-1:0]    win;
  logic               take;

  // Edge lines latch a rising edge until taken; a new edge in the take cycle
  // wins over the clear.
  // Level lines follow the raw request directly and never hold pend_q state.
  assign edge_rise = irq_req_i & ~req_q;
  assign pend_d    = (edge_rise | (pend_q & ~irq_ack_o)) & EDGE_MASK;
  assign pend      = (pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
  assign cand      = pend & irq_mask_i;

  // Lowest set index of the candidates wins.
  always_comb begin
    win = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (cand[i]) win = ID_W'(i);
    end
  end

  // A take happens only from IDLE and only when no exception arrives in the same cycle.
  // Gating with rst_ni keeps the combinational outputs quiet while reset is held.
  assign take = rst_ni & (state_q == ST_IDLE) & ~exception_i & mie_i & (|cand);

  assign irq_o     = take;
  assign irq_ret_o = rst_ni & (state_q == ST_IRQ) & mret_i & ~exception_i;
  assign irq_id_o  = take ? win : id_q;
  assign irq_cause_o = CAUSE_BASE + 32'(irq_id_o);

  for (genvar gi = 0; gi < IRQ_NUM; gi++) begin : g_ack
    assign irq_ack_o[gi] = take & (win == ID_W'(gi));
  end

  // Request sampling, pending latches and the serviced line index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= '0;
      pend_q <= '0;
      id_q   <= '0;
    end else begin
      req_q  <= irq_req_i;
      pend_q <= pend_d;
      if (take) id_q <= win;
    end
  end

  // Service state machine; exceptions take precedence over interrupts and mret.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exception_i)  state_q <= ST_EXC;
          else if (take)    state_q <= ST_IRQ;
        end
        ST_IRQ: begin
          if (exception_i)  state_q <= ST_EXC_IN_IRQ;
          else if (mret_i)  state_q <= ST_IDLE;
        end
        ST_EXC: begin
          if (mret_i)       state_q <= ST_IDLE;
        end
        ST_EXC_IN_IRQ: begin
          if (mret_i)       state_q <= ST_IRQ;
        end
        default:            state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller_multi.sv
// Directed testbench for irq_controller_multi.
// Line 1 is level sensitive and every other line is edge sensitive.
module tb_irq_controller_multi;

  logic        clk;
  logic        rst_n;
  logic        exception;
  logic        mret;
  logic        mie;
  logic [15:0] irq_req;
  logic [15:0] irq_mask;
  logic        irq;
  logic [31:0] cause;
  logic [3:0]  id;
  logic [15:0] ack;
  logic        ret;

  int tests_run    = 0;
  int tests_failed = 0;

  irq_controller_multi #(
    .IRQ_NUM   (16),
    .EDGE_MASK (16'hFFFD),
    .CAUSE_BASE(32'h1000_0010)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .exception_i(exception),
    .mret_i     (mret),
    .mie_i      (mie),
    .irq_req_i  (irq_req),
    .irq_mask_i (irq_mask),
    .irq_o      (irq),
    .irq_cause_o(cause),
    .irq_id_o   (id),
    .irq_ack_o  (ack),
    .irq_ret_o  (ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    irq_req[1] = 1'b1;
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL rst_irq got %b want 0", irq); end
    tests_run++; if (ack !== 16'h0000) begin tests_failed++; $display("FAIL rst_ack got %h want 0000", ack); end
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL rst_ret got %b want 0", ret); end
    tests_run++; if (id !== 4'd0) begin tests_failed++; $display("FAIL rst_id got %0d want 0", id); end
    tests_run++; if (cause !== 32'h1000_0010) begin tests_failed++; $display("FAIL rst_cause got %h want 10000010", cause); end
    irq_req = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL post_rst_irq got %b want 0", irq); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_edge();
    cyc(); irq_req[3] = 1'b1; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL edge_early got %b want 0", irq); end
    cyc(); irq_req[3] = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL edge_take got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0008) begin tests_failed++; $display("FAIL edge_ack got %h want 0008", ack); end
    tests_run++; if (cause !== 32'h1000_0013) begin tests_failed++; $display("FAIL edge_cause got %h want 10000013", cause); end
    tests_run++; if (id !== 4'd3) begin tests_failed++; $display("FAIL edge_id got %0d want 3", id); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL edge_pulse_irq got %b want 0", irq); end
    tests_run++; if (ack !== 16'h0000) begin tests_failed++; $display("FAIL edge_pulse_ack got %h want 0000", ack); end
    cyc(); cyc(); cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL edge_ret got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL edge_ret_pulse got %b want 0", ret); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL edge_cleared got %b want 0", irq); end
    $display("[TB] test_single_edge done");
  endtask

  task automatic test_priority();
    cyc(); irq_req = 16'h0204; #1;
    cyc(); irq_req = '0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL prio_take2 got %b want 1", irq); end
    tests_run++; if (cause !== 32'h1000_0012) begin tests_failed++; $display("FAIL prio_cause2 got %h want 10000012", cause); end
    tests_run++; if (ack !== 16'h0004) begin tests_failed++; $display("FAIL prio_ack2 got %h want 0004", ack); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio_no_nest got %b want 0", irq); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL prio_ret got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL prio_take9 got %b want 1", irq); end
    tests_run++; if (cause !== 32'h1000_0019) begin tests_failed++; $display("FAIL prio_cause9 got %h want 10000019", cause); end
    tests_run++; if (ack !== 16'h0200) begin tests_failed++; $display("FAIL prio_ack9 got %h want 0200", ack); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL prio_ret9 got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio_idle got %b want 0", irq); end
    $display("[TB] test_priority done");
  endtask

  task automatic test_mask_mie();
    cyc(); irq_mask = 16'hFFEF; irq_req[4] = 1'b1; #1;
    cyc(); irq_req[4] = 1'b0; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mask_blocked got %b want 0", irq); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mask_hold got %b want 0", irq); end
    cyc(); mie = 1'b0; irq_mask = 16'hFFFF; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL mie_blocked got %b want 0", irq); end
    cyc(); mie = 1'b1; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL mie_take got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0010) begin tests_failed++; $display("FAIL mie_ack got %h want 0010", ack); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL mie_ret got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    $display("[TB] test_mask_mie done");
  endtask

  task automatic test_exc_vs_irq();
    cyc(); irq_req[0] = 1'b1; #1;
    cyc(); irq_req[0] = 1'b0; exception = 1'b1; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL exc_beats_irq got %b want 0", irq); end
    tests_run++; if (ack !== 16'h0000) begin tests_failed++; $display("FAIL exc_no_ack got %h want 0000", ack); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL exc_state got %b want 0", irq); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL exc_ret got %b want 0", ret); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL exc_mret_irq got %b want 0", irq); end
    cyc(); exception = 1'b0; mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL exc_then_take got %b want 1", irq); end
    tests_run++; if (cause !== 32'h1000_0010) begin tests_failed++; $display("FAIL exc_cause0 got %h want 10000010", cause); end
    tests_run++; if (ack !== 16'h0001) begin tests_failed++; $display("FAIL exc_ack0 got %h want 0001", ack); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL exc_ret0 got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    $display("[TB] test_exc_vs_irq done");
  endtask

  task automatic test_exc_in_irq();
    cyc(); irq_req[5] = 1'b1; #1;
    cyc(); irq_req[5] = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL nest_take5 got %b want 1", irq); end
    tests_run++; if (id !== 4'd5) begin tests_failed++; $display("FAIL nest_id5 got %0d want 5", id); end
    cyc(); exception = 1'b1; mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL nest_exc_beats_mret got %b want 0", ret); end
    cyc(); exception = 1'b0; mret = 1'b0; irq_req[2] = 1'b1; #1;
    tests_run++; if (id !== 4'd5) begin tests_failed++; $display("FAIL nest_id_exc got %0d want 5", id); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL nest_irq_exc got %b want 0", irq); end
    cyc(); irq_req[2] = 1'b0; mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL nest_ret_first got %b want 0", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (id !== 4'd5) begin tests_failed++; $display("FAIL nest_id_back got %0d want 5", id); end
    tests_run++; if (cause !== 32'h1000_0015) begin tests_failed++; $display("FAIL nest_cause_back got %h want 10000015", cause); end
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL nest_no_nest got %b want 0", irq); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL nest_ret_second got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL nest_retake got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0004) begin tests_failed++; $display("FAIL nest_retake_ack got %h want 0004", ack); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL nest_ret2 got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    $display("[TB] test_exc_in_irq done");
  endtask

  task automatic test_set_beats_clear();
    cyc(); mie = 1'b0; irq_req[3] = 1'b1; #1;
    cyc(); irq_req[3] = 1'b0; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL sbc_mie_off got %b want 0", irq); end
    cyc(); mie = 1'b1; irq_req[3] = 1'b1; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL sbc_take got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0008) begin tests_failed++; $display("FAIL sbc_ack got %h want 0008", ack); end
    cyc(); irq_req[3] = 1'b0; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL sbc_in_irq got %b want 0", irq); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL sbc_ret got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL sbc_still_pending got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0008) begin tests_failed++; $display("FAIL sbc_ack2 got %h want 0008", ack); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL sbc_ret2 got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL sbc_cleared got %b want 0", irq); end
    $display("[TB] test_set_beats_clear done");
  endtask

  task automatic test_level_reset();
    cyc(); irq_req[1] = 1'b1; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL lvl_take got %b want 1", irq); end
    tests_run++; if (ack !== 16'h0002) begin tests_failed++; $display("FAIL lvl_ack got %h want 0002", ack); end
    tests_run++; if (cause !== 32'h1000_0011) begin tests_failed++; $display("FAIL lvl_cause got %h want 10000011", cause); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL lvl_pulse got %b want 0", irq); end
    cyc(); mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL lvl_ret got %b want 1", ret); end
    cyc(); mret = 1'b0; #1;
    tests_run++; if (irq !== 1'b1) begin tests_failed++; $display("FAIL lvl_retake got %b want 1", irq); end
    cyc(); irq_req[6] = 1'b1; #1;
    cyc(); irq_req[6] = 1'b0; mret = 1'b1; #1;
    tests_run++; if (ret !== 1'b1) begin tests_failed++; $display("FAIL lvl_ret_pre_rst got %b want 1", ret); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL arst_irq got %b want 0", irq); end
    tests_run++; if (ack !== 16'h0000) begin tests_failed++; $display("FAIL arst_ack got %h want 0000", ack); end
    tests_run++; if (ret !== 1'b0) begin tests_failed++; $display("FAIL arst_ret got %b want 0", ret); end
    tests_run++; if (id !== 4'd0) begin tests_failed++; $display("FAIL arst_id got %0d want 0", id); end
    tests_run++; if (cause !== 32'h1000_0010) begin tests_failed++; $display("FAIL arst_cause got %h want 10000010", cause); end
    irq_req = '0;
    mret = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL arst_edge_dropped got %b want 0", irq); end
    cyc(); #1;
    tests_run++; if (irq !== 1'b0) begin tests_failed++; $display("FAIL arst_quiet got %b want 0", irq); end
    $display("[TB] test_level_reset done");
  endtask

  initial begin
    rst_n     = 1'b0;
    exception = 1'b0;
    mret      = 1'b0;
    mie       = 1'b1;
    irq_req   = '0;
    irq_mask  = '1;
    test_reset();
    test_single_edge();
    test_priority();
    test_mask_mie();
    test_exc_vs_irq();
    test_exc_in_irq();
    test_set_beats_clear();
    test_level_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
